fnd_adder_4bit: RTL and testbench



---
 rtl/fnd_adder_4bit.sv | 123 ++++++++++++
 tb/tb_fnd_adder_4bit.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/fnd_adder_4bit.sv
// 4-bit adder shown in decimal on a 4-digit common-anode FND, one digit at a time.
// Optional macro FND_AUTOSCAN_EN replaces i_DS with an internal digit scanner.
module fnd_adder_4bit #(
    parameter int SCAN_DIV = 100000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [3:0] i_A,
    input  logic [3:0] i_B,
    input  logic       i_Cin,
    input  logic       i_EN,
    input  logic [1:0] i_DS,
    output logic [3:0] o_FND_Digit,
    output logic [7:0] o_FND_Font
);

    logic [4:0] sum;
    logic [3:0] ones;
    logic [3:0] tens;
    logic [3:0] code;
    logic [1:0] sel;
    logic [3:0] digit;
    logic [7:0] font;

    assign sum = {1'b0, i_A} + {1'b0, i_B} + {4'b0, i_Cin};

`ifdef FND_AUTOSCAN_EN
    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] scan_cnt;
    logic [1:0]    scan_idx;

    // Counter keeps running while blanked so the scan phase stays steady.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            scan_cnt <= '0;
            scan_idx <= '0;
        end else if (scan_cnt == LAST) begin
            scan_cnt <= '0;
            scan_idx <= scan_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign sel = scan_idx;

    logic unused_ds;
    assign unused_ds = ^i_DS;
`else
    assign sel = i_DS;
`endif

    // Sum is at most 31, so tens never exceeds 3.
    always_comb begin
        ones = 4'd0;
        tens = 4'd0;
        if (sum >= 5'd30) begin
            tens = 4'd3;
            ones = 4'(sum - 5'd30);
        end else if (sum >= 5'd20) begin
            tens = 4'd2;
            ones = 4'(sum - 5'd20);
        end else if (sum >= 5'd10) begin
            tens = 4'd1;
            ones = 4'(sum - 5'd10);
        end else begin
            ones = sum[3:0];
        end
    end

    always_comb begin
        code  = 4'hF;
        digit = 4'b1111;
        unique case (sel)
            2'd0: begin
                code  = ones;
                digit = 4'b1110;
            end
            2'd1: begin
                code  = tens;
                digit = 4'b1101;
            end
            2'd2: begin
                code  = {3'b000, sum[4]};
                digit = 4'b1011;
            end
            2'd3: begin
                code  = 4'hF;
                digit = 4'b0111;
            end
        endcase
    end

    always_comb begin
        font = 8'hFF;
        case (code)
            4'd0:    font = 8'hC0;
            4'd1:    font = 8'hF9;
            4'd2:    font = 8'hA4;
            4'd3:    font = 8'hB0;
            4'd4:    font = 8'h99;
            4'd5:    font = 8'h92;
            4'd6:    font = 8'h82;
            4'd7:    font = 8'hF8;
            4'd8:    font = 8'h80;
            4'd9:    font = 8'h90;
            default: font = 8'hFF;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset || i_EN) begin
            o_FND_Digit <= 4'b1111;
            o_FND_Font  <= 8'hFF;
        end else begin
            o_FND_Digit <= digit;
            o_FND_Font  <= font;
        end
    end

endmodule

// File: tb/tb_fnd_adder_4bit.sv
// Self-checking bench for fnd_adder_4bit against a decimal-arithmetic model.
// Define FND_AUTOSCAN_EN for both RTL and bench to exercise the scanner.
module tb_fnd_adder_4bit;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic       en;
    logic [1:0] ds;
    logic [3:0] dig;
    logic [7:0] fnt;

    int total = 0;
    int bad = 0;

    fnd_adder_4bit #(.SCAN_DIV(4)) dut (
        .i_clk(clk),
        .i_reset(rst),
        .i_A(a),
        .i_B(b),
        .i_Cin(cin),
        .i_EN(en),
        .i_DS(ds),
        .o_FND_Digit(dig),
        .o_FND_Font(fnt)
    );

    always #5 clk = ~clk;

    logic [7:0] font_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                  8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
    logic [3:0] dig_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    function automatic logic [11:0] model(input int av, input int bv,
                                          input int cv, input bit env,
                                          input int sv);
        int s;
        int val;
        s = av + bv + cv;
        case (sv)
            0: val = s % 10;
            1: val = s / 10;
            2: val = (s >= 16) ? 1 : 0;
            default: val = -1;
        endcase
        if (env) return {4'b1111, 8'hFF};
        return {dig_tab[sv], (val < 0) ? 8'hFF : font_tab[val]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input int av, input int bv, input int cv,
                          input bit env, input int sv);
        a   = 4'(av);
        b   = 4'(bv);
        cin = 1'(cv);
        en  = env;
        ds  = 2'(sv);
    endtask

    task automatic test_reset();
        logic [11:0] exp;
        rst = 1'b1;
        set_in(0, 1, 0, 1'b0, 0);
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({dig, fnt} !== 12'hFFF) begin
                bad++;
                $display("FAIL reset[%0d] got=%h/%h want=f/ff", i, dig, fnt);
            end
        end
        rst = 1'b0;
        tick();
        exp = model(0, 1, 0, 1'b0, 0);
        total++;
        if ({dig, fnt} !== exp || exp !== {4'b1110, 8'hF9}) begin
            bad++;
            $display("FAIL reset_release got=%h/%h want=%h", dig, fnt, exp);
        end
    endtask

    task automatic test_blank();
        set_in(0, 1, 0, 1'b1, 0);
        tick();
        total++;
        if ({dig, fnt} !== 12'hFFF) begin
            bad++;
            $display("FAIL blank got=%h/%h want=f/ff", dig, fnt);
        end
        set_in(1, 1, 0, 1'b0, 0);
        tick();
        total++;
        if ({dig, fnt} !== {4'b1110, 8'hA4}) begin
            bad++;
            $display("FAIL unblank got=%h/%h want=e/a4", dig, fnt);
        end
    endtask

    task automatic test_select();
        int vec [11][5] = '{
            '{2, 1, 0, 1, 12'hDC0},
            '{3, 1, 0, 2, 12'hBC0},
            '{4, 1, 0, 3, 12'h7FF},
            '{4, 8, 0, 0, 12'hEA4},
            '{4, 8, 0, 1, 12'hDF9},
            '{4, 8, 0, 2, 12'hBC0},
            '{15, 15, 1, 0, 12'hEF9},
            '{15, 15, 1, 1, 12'hDB0},
            '{15, 15, 1, 2, 12'hBF9},
            '{9, 0, 1, 0, 12'hEC0},
            '{9, 0, 1, 1, 12'hDF9}
        };
        for (int i = 0; i < 11; i++) begin
            set_in(vec[i][0], vec[i][1], vec[i][2], 1'b0, vec[i][3]);
            tick();
            total++;
            if ({dig, fnt} !== 12'(vec[i][4])) begin
                bad++;
                $display("FAIL select[%0d] got=%h/%h want=%h",
                         i, dig, fnt, 12'(vec[i][4]));
            end
        end
    endtask

    task automatic test_back_to_back();
        int av, bv, cv, sv;
        bit env;
        logic [11:0] exp;
        for (int i = 0; i < 300; i++) begin
            av  = $urandom_range(0, 15);
            bv  = $urandom_range(0, 15);
            cv  = $urandom_range(0, 1);
            sv  = $urandom_range(0, 3);
            env = ($urandom_range(0, 7) == 0);
            set_in(av, bv, cv, env, sv);
            exp = model(av, bv, cv, env, sv);
            tick();
            total++;
            if ({dig, fnt} !== exp) begin
                bad++;
                $display("FAIL rand[%0d] a=%0d b=%0d c=%0d en=%0d ds=%0d got=%h/%h want=%h",
                         i, av, bv, cv, env, sv, dig, fnt, exp);
            end
        end
        set_in(15, 15, 1, 1'b0, 1);
        rst = 1'b1;
        tick();
        total++;
        if ({dig, fnt} !== 12'hFFF) begin
            bad++;
            $display("FAIL reset_override got=%h/%h want=f/ff", dig, fnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_autoscan();
        logic [11:0] exp;
        bit env;
        int idx;
        rst = 1'b1;
        set_in(4, 8, 0, 1'b0, 0);
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            env = (k == 10 || k == 11);
            set_in(4, 8, 0, env, $urandom_range(0, 3));
            idx = ((k - 1) / 4) % 4;
            exp = model(4, 8, 0, env, idx);
            tick();
            total++;
            if ({dig, fnt} !== exp) begin
                bad++;
                $display("FAIL scan[%0d] got=%h/%h want=%h", k, dig, fnt, exp);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        set_in(0, 0, 0, 1'b1, 0);
        test_reset();
`ifdef FND_AUTOSCAN_EN
        test_autoscan();
`else
        test_blank();
        test_select();
        test_back_to_back();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
